// File: rtl/sort_param_ctrl.sv
// rtl/sort_param_ctrl.sv - in-place bubble sort sequencer over an external single-port memory
module sort_param_ctrl #(
    parameter int DW  = 8,
    parameter int AW  = 5,
    parameter int SCW = 16
) (
    input  logic           t_clk,
    input  logic           t_s_rst,
    input  logic           t_s_go,
    input  logic [AW:0]    t_n,
    input  logic           t_mode,
    input  logic [DW-1:0]  t_rdata,
    output logic [AW-1:0]  t_d_add,
    output logic [DW-1:0]  t_wd_val,
    output logic           t_s_dmr,
    output logic           t_s_dmw,
    output logic           t_busy,
    output logic           t_done,
    output logic [SCW-1:0] t_swaps
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD1, S_RD2, S_LD2, S_CMP, S_WR1, S_WR2, S_NEXT, S_DONE
    } state_t;

    localparam logic [AW:0] N_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [DW-1:0]  t1_q, t1_d, t2_q, t2_d;
    logic [AW-1:0]  c_q, c_d;
    logic [AW:0]    lim_q, lim_d;
    logic           mode_q, mode_d;
    logic           swapped_q, swapped_d;
    logic [SCW-1:0] swaps_q, swaps_d;

    logic [AW:0]    n_r;
    logic [AW:0]    c_inc;
    logic           do_swap;

    // Element count is clamped so an oversize request sorts the whole memory.
    assign n_r     = (t_n > N_MAX) ? N_MAX : t_n;
    assign c_inc   = {1'b0, c_q} + ONE;
    assign do_swap = mode_q ? (t1_q < t2_q) : (t1_q > t2_q);
    assign t_swaps = swaps_q;

    always_ff @(posedge t_clk or posedge t_s_rst) begin
        if (t_s_rst) begin
            state_q   <= S_IDLE;
            t1_q      <= '0;
            t2_q      <= '0;
            c_q       <= '0;
            lim_q     <= '0;
            mode_q    <= 1'b0;
            swapped_q <= 1'b0;
            swaps_q   <= '0;
        end else begin
            state_q   <= state_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            c_q       <= c_d;
            lim_q     <= lim_d;
            mode_q    <= mode_d;
            swapped_q <= swapped_d;
            swaps_q   <= swaps_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        c_d       = c_q;
        lim_d     = lim_q;
        mode_d    = mode_q;
        swapped_d = swapped_q;
        swaps_d   = swaps_q;
        case (state_q)
            S_IDLE: begin
                if (t_s_go) begin
                    mode_d    = t_mode;
                    swaps_d   = '0;
                    c_d       = '0;
                    swapped_d = 1'b0;
                    if (n_r <= ONE) begin
                        lim_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        lim_d   = n_r - ONE;
                        state_d = S_RD1;
                    end
                end
            end
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                t1_d    = t_rdata;
                state_d = S_LD2;
            end
            S_LD2: begin
                t2_d    = t_rdata;
                state_d = S_CMP;
            end
            S_CMP: state_d = do_swap ? S_WR1 : S_NEXT;
            S_WR1: state_d = S_WR2;
            S_WR2: begin
                swapped_d = 1'b1;
                if (swaps_q != {SCW{1'b1}}) begin
                    swaps_d = swaps_q + 1'b1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (c_inc < lim_q) begin
                    c_d     = c_inc[AW-1:0];
                    state_d = S_RD1;
                end else if (!swapped_q || lim_q == ONE) begin
                    state_d = S_DONE;
                end else begin
                    lim_d     = lim_q - ONE;
                    c_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = S_RD1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        t_d_add  = '0;
        t_wd_val = '0;
        t_s_dmr  = 1'b0;
        t_s_dmw  = 1'b0;
        t_busy   = (state_q != S_IDLE);
        t_done   = (state_q == S_DONE);
        case (state_q)
            S_RD1: begin
                t_s_dmr = 1'b1;
                t_d_add = c_q;
            end
            S_RD2: begin
                t_s_dmr = 1'b1;
                t_d_add = c_inc[AW-1:0];
            end
            S_WR1: begin
                t_s_dmw  = 1'b1;
                t_d_add  = c_q;
                t_wd_val = t2_q;
            end
            S_WR2: begin
                t_s_dmw  = 1'b1;
                t_d_add  = c_inc[AW-1:0];
                t_wd_val = t1_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sort_param_ctrl.sv
// tb/tb_sort_param_ctrl.sv - directed bench for sort_param_ctrl with a synchronous-read memory model
module tb_sort_param_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [5:0]  t_n = '0;
    logic        mode = 1'b0;
    logic [7:0]  rdata = '0;
    logic [4:0]  addr;
    logic [7:0]  wd;
    logic        dmr, dmw, busy, done;
    logic [15:0] swaps;

    logic [7:0]  mem [32];
    logic [7:0]  img [32];
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, a31_cnt = 0;

    int nvec = 0;
    int nerr = 0;

    sort_param_ctrl dut (
        .t_clk(clk), .t_s_rst(rst), .t_s_go(go), .t_n(t_n), .t_mode(mode),
        .t_rdata(rdata), .t_d_add(addr), .t_wd_val(wd), .t_s_dmr(dmr),
        .t_s_dmw(dmw), .t_busy(busy), .t_done(done), .t_swaps(swaps)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (dmw) mem[addr] <= wd;
        if (dmr) rdata <= mem[addr];
        if (dmr) rd_cnt <= rd_cnt + 1;
        if (dmw) wr_cnt <= wr_cnt + 1;
        if (dmr && dmw) both_cnt <= both_cnt + 1;
        if (dmr && addr == 5'd31) a31_cnt <= a31_cnt + 1;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_mem(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            ld_en = 1'b1; ld_addr = 5'(i); ld_data = img[i];
            step();
        end
        ld_en = 1'b0;
    endtask

    task automatic start(input logic [5:0] n, input logic m);
        go = 1'b1; t_n = n; mode = m;
        step();
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        nvec++; if ({busy, done, dmr, dmw} !== 4'b0) begin nerr++; $display("FAIL reset_ctrl got %b exp 0000", {busy, done, dmr, dmw}); end
        nvec++; if ({addr, wd, swaps} !== 29'd0) begin nerr++; $display("FAIL reset_data got %h exp 0", {addr, wd, swaps}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_reverse5();
        int k;
        for (int i = 0; i < 5; i++) img[i] = 8'(5 - i);
        load_mem(5);
        start(6'd5, 1'b0);
        wait_done(200, k);
        nvec++; if (k !== 70) begin nerr++; $display("FAIL rev5_cycles got %0d exp 70", k); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rev5_busy_at_done got %b exp 1", busy); end
        nvec++; if (swaps !== 16'd10) begin nerr++; $display("FAIL rev5_swaps got %0d exp 10", swaps); end
        step();
        nvec++; if ({busy, done} !== 2'b00) begin nerr++; $display("FAIL rev5_after_done got %b exp 00", {busy, done}); end
        for (int i = 0; i < 5; i++) begin
            nvec++; if (mem[i] !== 8'(i + 1)) begin nerr++; $display("FAIL rev5_mem[%0d] got %0d exp %0d", i, mem[i], i + 1); end
        end
        step();
        nvec++; if (swaps !== 16'd10) begin nerr++; $display("FAIL rev5_swaps_hold got %0d exp 10", swaps); end
    endtask

    task automatic test_sorted4();
        int k, r0, w0;
        for (int i = 0; i < 4; i++) img[i] = 8'(i + 1);
        load_mem(4);
        r0 = rd_cnt; w0 = wr_cnt;
        start(6'd4, 1'b0);
        // 15 edges after the accept edge: 17 cycles counting the go cycle and DONE
        wait_done(100, k);
        nvec++; if (k !== 15) begin nerr++; $display("FAIL sorted4_cycles got %0d exp 15", k); end
        nvec++; if (swaps !== 16'd0) begin nerr++; $display("FAIL sorted4_swaps got %0d exp 0", swaps); end
        nvec++; if (wr_cnt - w0 !== 0) begin nerr++; $display("FAIL sorted4_writes got %0d exp 0", wr_cnt - w0); end
        nvec++; if (rd_cnt - r0 !== 6) begin nerr++; $display("FAIL sorted4_reads got %0d exp 6", rd_cnt - r0); end
        step();
    endtask

    task automatic test_desc_equal();
        int k, w0;
        img[0] = 8'd2; img[1] = 8'd7; img[2] = 8'd7; img[3] = 8'd1;
        load_mem(4);
        w0 = wr_cnt;
        start(6'd4, 1'b1);
        wait_done(100, k);
        nvec++; if (k !== 29) begin nerr++; $display("FAIL desc_cycles got %0d exp 29", k); end
        nvec++; if (swaps !== 16'd2) begin nerr++; $display("FAIL desc_swaps got %0d exp 2", swaps); end
        nvec++; if (wr_cnt - w0 !== 4) begin nerr++; $display("FAIL desc_writes got %0d exp 4", wr_cnt - w0); end
        nvec++; if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h07070201) begin nerr++; $display("FAIL desc_mem got %h exp 07070201", {mem[0], mem[1], mem[2], mem[3]}); end
        step();
    endtask

    task automatic test_small_n();
        int k, r0, w0;
        for (int n = 0; n < 2; n++) begin
            r0 = rd_cnt; w0 = wr_cnt;
            start(6'(n), 1'b0);
            wait_done(10, k);
            nvec++; if (k !== 0) begin nerr++; $display("FAIL small_n%0d_cycles got %0d exp 0", n, k); end
            step();
            nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL small_n%0d_idle got %b exp 0", n, busy); end
            nvec++; if ((rd_cnt - r0) + (wr_cnt - w0) !== 0) begin nerr++; $display("FAIL small_n%0d_mem_access got %0d exp 0", n, (rd_cnt - r0) + (wr_cnt - w0)); end
        end
    endtask

    task automatic test_done_go();
        go = 1'b1; t_n = 6'd1; mode = 1'b0;
        step();
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL done_go_pulse got %b exp 1", done); end
        step();
        nvec++; if ({busy, done} !== 2'b00) begin nerr++; $display("FAIL done_go_restart got %b exp 00", {busy, done}); end
        go = 1'b0;
        step();
    endtask

    task automatic test_full32();
        int k, inv, a0, tmp;
        int exp_v [32];
        for (int i = 0; i < 32; i++) begin
            img[i] = 8'($urandom_range(0, 255));
            exp_v[i] = int'(img[i]);
        end
        inv = 0;
        for (int i = 0; i < 32; i++)
            for (int j = i + 1; j < 32; j++)
                if (exp_v[i] > exp_v[j]) inv++;
        for (int i = 1; i < 32; i++)
            for (int j = i; j > 0 && exp_v[j-1] > exp_v[j]; j--) begin
                tmp = exp_v[j]; exp_v[j] = exp_v[j-1]; exp_v[j-1] = tmp;
            end
        load_mem(32);
        a0 = a31_cnt;
        start(6'd40, 1'b0);
        for (int i = 0; i < 100; i++) step();
        go = 1'b1; t_n = 6'd3; mode = 1'b1;
        step();
        go = 1'b0;
        wait_done(6000, k);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL full32_timeout got %b exp 1", done); end
        nvec++; if (swaps !== 16'(inv)) begin nerr++; $display("FAIL full32_swaps got %0d exp %0d", swaps, inv); end
        nvec++; if ((a31_cnt - a0 > 0) !== 1'b1) begin nerr++; $display("FAIL full32_addr31 got %0d reads exp >0", a31_cnt - a0); end
        for (int i = 0; i < 32; i++) begin
            nvec++; if (int'(mem[i]) !== exp_v[i]) begin nerr++; $display("FAIL full32_mem[%0d] got %0d exp %0d", i, mem[i], exp_v[i]); end
        end
        step();
    endtask

    task automatic test_reset_wr1();
        int k;
        for (int i = 0; i < 5; i++) img[i] = 8'(5 - i);
        load_mem(5);
        start(6'd5, 1'b0);
        k = 0;
        while (!(dmw === 1'b1 && swaps == 16'd1) && k < 100) begin step(); k++; end
        nvec++; if (k >= 100) begin nerr++; $display("FAIL rst_wr1_reach got timeout exp second WR1"); end
        rst = 1'b1;
        #1;
        nvec++; if ({busy, done, dmr, dmw} !== 4'b0) begin nerr++; $display("FAIL rst_wr1_ctrl got %b exp 0000", {busy, done, dmr, dmw}); end
        nvec++; if ({addr, wd, swaps} !== 29'd0) begin nerr++; $display("FAIL rst_wr1_data got %h exp 0", {addr, wd, swaps}); end
        step();
        img[0] = 8'd3; img[1] = 8'd1; img[2] = 8'd2;
        load_mem(3);
        rst = 1'b0;
        start(6'd3, 1'b0);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rst_first_accept got %b exp 1", busy); end
        wait_done(100, k);
        nvec++; if (k !== 19) begin nerr++; $display("FAIL rst_resort_cycles got %0d exp 19", k); end
        nvec++; if (swaps !== 16'd2) begin nerr++; $display("FAIL rst_resort_swaps got %0d exp 2", swaps); end
        nvec++; if ({mem[0], mem[1], mem[2]} !== 24'h010203) begin nerr++; $display("FAIL rst_resort_mem got %h exp 010203", {mem[0], mem[1], mem[2]}); end
        step();
    endtask

    task automatic test_strobe_exclusive();
        nvec++; if (both_cnt !== 0) begin nerr++; $display("FAIL strobe_overlap got %0d exp 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_reverse5();
        test_sorted4();
        test_desc_equal();
        test_small_n();
        test_done_go();
        test_full32();
        test_reset_wr1();
        test_strobe_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
